data_memory_mc: RTL

Multi-cycle, parametrised successor to the single-cycle data memory. It provides a word array with byte, halfword and word access, sign or zero extension on loads, and a configurable wait-state latency. Requests use a Req/Ready handshake, so the pipeline's MEM stage can stall on Busy. It sits between the EX/MEM register and the MEM/WB register.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_lane_align.sv | 82 ++++++++
 rtl/data_memory_mc.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data memory: access size codes,
// FSM state codes and the wait-state counter width helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] WAIT = 2'b01;
    localparam logic [1:0] DONE = 2'b10;

    // The counter holds values LATENCY-1 down to 0; keep at least one bit.
    function automatic int latencyCntWidth(input int latency);
        if (latency <= 2) begin
            return 1;
        end else begin
            return $clog2(latency);
        end
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data memory.
// Stores: merges right-justified store data into the old word on the
// addressed lanes. Loads: extracts the addressed lanes and sign/zero extends.
// Offsets are always masked to natural alignment; the misaligned flag lets
// the parent decide whether to trap or proceed.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        isUnsigned,
    input  logic [1:0]  byteOff,
    input  logic [31:0] writeData,
    input  logic [31:0] oldWord,
    output logic [31:0] mergedWord,
    output logic [31:0] loadData,
    output logic        misaligned
);

    logic [1:0]  effOff_s;
    logic [3:0]  byteEn_s;
    logic [31:0] shiftedWrite_s;
    logic [31:0] shiftedRead_s;

    // Decode the effective lane offset, byte enables and misalignment.
    always_comb begin
        effOff_s   = 2'b00;
        byteEn_s   = 4'b1111;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                effOff_s   = byteOff;
                byteEn_s   = 4'b0001 << byteOff;
                misaligned = 1'b0;
            end
            SIZE_HALF: begin
                effOff_s   = {byteOff[1], 1'b0};
                byteEn_s   = 4'b0011 << {byteOff[1], 1'b0};
                misaligned = byteOff[0];
            end
            default: begin
                effOff_s   = 2'b00;
                byteEn_s   = 4'b1111;
                misaligned = (byteOff != 2'b00);
            end
        endcase
    end

    // Merge shifted store data into the old word, lane by lane.
    always_comb begin
        shiftedWrite_s = writeData << {effOff_s, 3'b000};
        mergedWord     = oldWord;
        for (int i = 0; i < 4; i++) begin
            mergedWord[8*i +: 8] = byteEn_s[i] ? shiftedWrite_s[8*i +: 8] : oldWord[8*i +: 8];
        end
    end

    // Extract the addressed lanes and extend to 32 bits.
    always_comb begin
        shiftedRead_s = oldWord >> {effOff_s, 3'b000};
        loadData      = shiftedRead_s;
        case (size)
            SIZE_BYTE: begin
                if (isUnsigned) begin
                    loadData = {24'h000000, shiftedRead_s[7:0]};
                end else begin
                    loadData = {{24{shiftedRead_s[7]}}, shiftedRead_s[7:0]};
                end
            end
            SIZE_HALF: begin
                if (isUnsigned) begin
                    loadData = {16'h0000, shiftedRead_s[15:0]};
                end else begin
                    loadData = {{16{shiftedRead_s[15]}}, shiftedRead_s[15:0]};
                end
            end
            default: begin
                loadData = shiftedRead_s;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle data memory with Req/Ready handshake and LATENCY wait states.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses complete
// with Misaligned=1 and no side effects; otherwise low address bits are masked.
module data_memory_mc
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic [1:0]        Size,
    input  logic              Unsigned,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              Ready,
    output logic              Busy,
    output logic              Misaligned
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = latencyCntWidth(LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    logic [1:0]       state_r, nextState_s;
    logic [CNT_W-1:0] cnt_r;
    logic [IDX_W+1:0] addr_r, opAddr_s;
    logic [1:0]       size_r, opSize_s;
    logic             unsigned_r, opUnsigned_s;
    logic [31:0]      wdata_r, opWdata_s;
    logic             isWrite_r, opIsWrite_s;
    logic [31:0]      readData_r;
    logic             ready_r, busy_r, misaligned_r;
    logic [31:0]      memArray_r [DEPTH];

    logic             accept_s, enterDone_s, fault_s;
    logic             commitWrite_s, commitRead_s;
    logic [31:0]      oldWord_s, mergedWord_s, loadData_s;
    logic             laneMisaligned_s;
    logic             unusedAddr_s;

    // Upper address bits only wrap the index and are otherwise ignored.
    assign unusedAddr_s = ^{1'b0, Address};

    assign accept_s = (state_r == IDLE) && Req && (MemWrite || MemRead);

    // Operand source: live inputs in IDLE (LATENCY=1 commits on accept), latched otherwise.
    always_comb begin
        if (state_r == IDLE) begin
            opAddr_s     = Address[IDX_W+1:0];
            opSize_s     = Size;
            opUnsigned_s = Unsigned;
            opWdata_s    = WriteData;
            opIsWrite_s  = MemWrite;
        end else begin
            opAddr_s     = addr_r;
            opSize_s     = size_r;
            opUnsigned_s = unsigned_r;
            opWdata_s    = wdata_r;
            opIsWrite_s  = isWrite_r;
        end
    end

    // Next-state logic for the IDLE/WAIT/DONE handshake.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    nextState_s = (LATENCY == 1) ? DONE : WAIT;
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    nextState_s = DONE;
                end else begin
                    nextState_s = WAIT;
                end
            end
            DONE:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    assign enterDone_s = (nextState_s == DONE);

`ifdef DMEM_MISALIGN_TRAP_EN
    assign fault_s = laneMisaligned_s;
`else
    logic unusedMisalign_s;
    assign unusedMisalign_s = laneMisaligned_s;
    assign fault_s          = 1'b0;
`endif

    assign commitWrite_s = enterDone_s && opIsWrite_s && !fault_s;
    assign commitRead_s  = enterDone_s && !opIsWrite_s && !fault_s;
    assign oldWord_s     = memArray_r[opAddr_s[IDX_W+1:2]];

    dmem_lane_align uLaneAlign (
        .size       (opSize_s),
        .isUnsigned (opUnsigned_s),
        .byteOff    (opAddr_s[1:0]),
        .writeData  (opWdata_s),
        .oldWord    (oldWord_s),
        .mergedWord (mergedWord_s),
        .loadData   (loadData_s),
        .misaligned (laneMisaligned_s)
    );

    // FSM state, wait counter and request latch.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            addr_r     <= {(IDX_W+2){1'b0}};
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            wdata_r    <= 32'h00000000;
            isWrite_r  <= 1'b0;
        end else begin
            state_r <= nextState_s;
            if (accept_s) begin
                cnt_r      <= CNT_LOAD;
                addr_r     <= Address[IDX_W+1:0];
                size_r     <= Size;
                unsigned_r <= Unsigned;
                wdata_r    <= WriteData;
                isWrite_r  <= MemWrite;
            end else if ((state_r == WAIT) && (cnt_r != {CNT_W{1'b0}})) begin
                cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered handshake outputs and load result.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            readData_r   <= 32'h00000000;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            misaligned_r <= 1'b0;
        end else begin
            ready_r      <= enterDone_s;
            busy_r       <= (nextState_s != IDLE);
            misaligned_r <= enterDone_s && fault_s;
            if (commitRead_s) begin
                readData_r <= loadData_s;
            end
        end
    end

    // Array write on the edge entering DONE; contents survive reset.
    always_ff @(posedge Clk) begin
        if (commitWrite_s) begin
            memArray_r[opAddr_s[IDX_W+1:2]] <= mergedWord_s;
        end
    end

    assign ReadData   = readData_r;
    assign Ready      = ready_r;
    assign Busy       = busy_r;
    assign Misaligned = misaligned_r;

endmodule
